// File: rtl/led_matrix_scan_pkg.sv
// Shared constants and scan state encoding for the LED matrix scan controller.
package led_pkg;
    localparam int MATRIX_ROWS = 16;
    localparam int COL_W       = 16;
    localparam int ROM_ADDR_W  = 6;
    localparam int CHAR_IDX_W  = 2;
    localparam int ROW_IDX_W   = ROM_ADDR_W - CHAR_IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;
endpackage

// File: rtl/led_matrix_scan_if.sv
// ROM-side and matrix-side signals of the scan controller, bundled as one port.
interface led_scan_if;
    import led_pkg::*;
    logic                  i_en;
    logic                  i_pause;
    logic [ROM_ADDR_W-1:0] o_addr;
    logic [COL_W-1:0]      i_row;
    logic [MATRIX_ROWS-1:0] o_row_sel;
    logic [COL_W-1:0]      o_col;
    logic [CHAR_IDX_W-1:0] o_char_idx;
    logic                  o_frame_tick;

    modport master (
        input  i_en, i_pause, i_row,
        output o_addr, o_row_sel, o_col, o_char_idx, o_frame_tick
    );
    modport slave (
        output i_en, i_pause, i_row,
        input  o_addr, o_row_sel, o_col, o_char_idx, o_frame_tick
    );
endinterface

// File: rtl/led_matrix_scan_ticker.sv
// Phase counter: counts while running and strobes o_done on the terminal count.
module scan_ticker #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_run,
    input  logic [W-1:0] i_last,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    assign o_done = i_run && (r_cnt == i_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr || o_done)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/led_matrix_scan.sv
// Row-at-a-time LED matrix scanner: blank gap, lit row, frame and glyph sequencing.
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int BLANK_CYCLES    = 2,
    parameter int ROW_CYCLES      = 4,
    parameter int FRAMES_PER_CHAR = 2,
    parameter int CHAR_COUNT      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    led_scan_if.master bus
);
    localparam int PH_MAX = (BLANK_CYCLES > ROW_CYCLES) ? BLANK_CYCLES : ROW_CYCLES;
    localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int FW     = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;

    scan_state_e            r_state;
    logic [ROW_IDX_W-1:0]   r_row;
    logic [FW-1:0]          r_frame;
    logic [CHAR_IDX_W-1:0]  r_char;
    logic [ROM_ADDR_W-1:0]  r_addr;
    logic [MATRIX_ROWS-1:0] r_row_sel;
    logic [COL_W-1:0]       r_col;
    logic                   r_tick;

    logic                   w_run, w_clr, w_done;
    logic [CW-1:0]          w_last;
    logic                   w_frame_end, w_frame_last, w_char_adv;
    logic [CHAR_IDX_W-1:0]  w_char_nxt;

    // Disable clears the phase counter so a re-enable always starts a clean row.
    assign w_run  = bus.i_en && (r_state != IDLE);
    assign w_clr  = !bus.i_en || (r_state == IDLE);
    assign w_last = (r_state == SHOW) ? CW'(ROW_CYCLES - 1) : CW'(BLANK_CYCLES - 1);

    scan_ticker #(.W(CW)) u_ticker (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_run   (w_run),
        .i_last  (w_last),
        .o_done  (w_done)
    );

    assign w_frame_end  = (r_state == SHOW) && w_done && (r_row == ROW_IDX_W'(MATRIX_ROWS - 1));
    assign w_frame_last = (r_frame == FW'(FRAMES_PER_CHAR - 1));
    assign w_char_adv   = w_frame_end && w_frame_last && !bus.i_pause;
    assign w_char_nxt   = !w_char_adv ? r_char :
                          (r_char == CHAR_IDX_W'(CHAR_COUNT - 1)) ? '0 : r_char + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_frame   <= '0;
            r_char    <= '0;
            r_addr    <= '0;
            r_row_sel <= '0;
            r_col     <= '0;
            r_tick    <= 1'b0;
        end else if (!bus.i_en) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_frame   <= '0;
            r_addr    <= {r_char, {ROW_IDX_W{1'b0}}};
            r_row_sel <= '0;
            r_col     <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_row_sel <= '0;
                    r_col     <= '0;
                    r_state   <= BLANK;
                end
                BLANK: begin
                    r_row_sel <= '0;
                    r_col     <= '0;
                    if (w_done) begin
                        r_col     <= bus.i_row;
                        r_row_sel <= {{(MATRIX_ROWS-1){1'b0}}, 1'b1} << r_row;
                        r_state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (w_done) begin
                        r_row_sel <= '0;
                        r_col     <= '0;
                        r_row     <= r_row + 1'b1;
                        r_char    <= w_char_nxt;
                        r_addr    <= {w_char_nxt, r_row + 1'b1};
                        r_state   <= BLANK;
                        if (w_frame_end) begin
                            r_tick <= 1'b1;
                            // A paused last frame holds its count so the advance fires later.
                            if (!w_frame_last)
                                r_frame <= r_frame + 1'b1;
                            else if (!bus.i_pause)
                                r_frame <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_addr       = r_addr;
    assign bus.o_row_sel    = r_row_sel;
    assign bus.o_col        = r_col;
    assign bus.o_char_idx   = r_char;
    assign bus.o_frame_tick = r_tick;
endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench: expected outputs come from a closed-form timeline model of the scan.
module tb_led_matrix_scan;
    localparam int ROWP  = 6;
    localparam int FRMP  = 96;
    localparam int CHARP = 192;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] row_sel;
        logic [15:0] col;
        logic [1:0]  chr;
        logic        tick;
    } exp_t;

    logic clk, rst_n;
    int   n_chk, n_err, n_tick;
    exp_t sb[$];

    led_scan_if bus();

    led_matrix_scan dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [15:0] rom(input logic [5:0] a);
        return (a == 6'd0) ? 16'hA5A5 : {a, ~a, a[3:0]};
    endfunction

    assign bus.i_row = rom(bus.o_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // k counts cycles from the first BLANK cycle after enable.
    function automatic exp_t model(input int k, input int base, input int adv_at);
        exp_t e;
        int c, row, ph;
        c   = (k < adv_at) ? base : (base + 1 + (k - adv_at) / CHARP) % 4;
        row = (k / ROWP) % 16;
        ph  = k % ROWP;
        e.addr    = {c[1:0], row[3:0]};
        e.chr     = c[1:0];
        e.row_sel = (ph >= 2) ? (16'd1 << row) : 16'd0;
        e.col     = (ph >= 2) ? rom(e.addr) : 16'd0;
        e.tick    = (k > 0) && (k % FRMP == 0);
        return e;
    endfunction

    task automatic cmp_out(input exp_t e);
        chk("addr", bus.o_addr, e.addr);
        chk("row_sel", bus.o_row_sel, e.row_sel);
        chk("col", bus.o_col, e.col);
        chk("char_idx", bus.o_char_idx, e.chr);
        chk("frame_tick", bus.o_frame_tick, e.tick);
        chk("onehot0", $onehot0(bus.o_row_sel), 1);
        chk("col_implies_row", (bus.o_col != 0) && (bus.o_row_sel == 0), 0);
    endtask

    task automatic run(input int k0, input int n, input int base, input int adv_at);
        exp_t e;
        for (int k = k0; k < k0 + n; k++) begin
            sb.push_back(model(k, base, adv_at));
            @(posedge clk); #1;
            e = sb.pop_front();
            cmp_out(e);
            if (k >= 1 && k <= CHARP && bus.o_frame_tick) n_tick++;
        end
    endtask

    task automatic idle_cycles(input int n, input logic [1:0] c);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{addr: {c, 4'd0}, row_sel: 16'd0, col: 16'd0, chr: c, tick: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            cmp_out(e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, bus.o_addr, 0);
        chk({tag, "_row_sel"}, bus.o_row_sel, 0);
        chk({tag, "_col"}, bus.o_col, 0);
        chk({tag, "_char"}, bus.o_char_idx, 0);
        chk({tag, "_tick"}, bus.o_frame_tick, 0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_tick = 0;
        rst_n = 1'b0;
        bus.i_en = 1'b0;
        bus.i_pause = 1'b0;
        #3;
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Four full characters, wrap back to 0, then on to char 1 row 7 mid-SHOW.
        bus.i_en = 1'b1;
        run(0, 1006, 0, CHARP);
        chk("ticks_in_192", n_tick, 2);

        bus.i_en = 1'b0;
        idle_cycles(3, 2'd1);

        // Re-enable resumes the held character from row 0 with a fresh frame count.
        bus.i_en = 1'b1;
        run(0, 200, 1, CHARP);

        bus.i_en = 1'b0;
        idle_cycles(2, 2'd2);

        // Pause across several frame ends; advance lands on the first end after release.
        bus.i_pause = 1'b1;
        bus.i_en = 1'b1;
        run(0, 300, 2, 2 * CHARP);
        bus.i_pause = 1'b0;
        run(300, 300, 2, 2 * CHARP);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        #10;
        chk_zero("rst_held");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
